wb_port_arbiter: RTL

- Shares the single register-file write port between two sources:
  - the in-order write-back stage, taken from the MEM/WB pipeline register outputs;
  - a long-latency unit (multi-cycle divider/CSR return path).
- Long-latency results are held in a small FIFO and drained into idle write-back slots.
- A starvation counter forces a one-cycle pipeline stall when a FIFO result has waited too long.
- Sits between the MEM/WB register and the register file. pipe_stall feeds the hazard/stall logic.

---
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Shares the register-file write port between the write-back stage
//            and a long-latency unit that is buffered in a FIFO.
//            Optional pending-register scoreboard: WB_ARB_SCOREBOARD_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module wb_port_arbiter #(
  parameter int XLEN        = `XLEN,
  parameter int RFIDX_WIDTH = `RFIDX_WIDTH,
  parameter int FIFO_DEPTH  = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_reg_write,
  input  logic                   wb_memtoreg,
  input  logic [XLEN-1:0]        m_data,
  input  logic [XLEN-1:0]        ex_result,
  input  logic [RFIDX_WIDTH-1:0] rd_index,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [RFIDX_WIDTH-1:0] lu_rd_index,
  input  logic [XLEN-1:0]        lu_data,
  output logic                   rf_wen,
  output logic [RFIDX_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
`ifdef WB_ARB_SCOREBOARD_EN
  input  logic                   lu_issue,
  input  logic [RFIDX_WIDTH-1:0] lu_issue_rd,
  input  logic [RFIDX_WIDTH-1:0] chk_rs1,
  input  logic [RFIDX_WIDTH-1:0] chk_rs2,
  output logic                   rs_hazard,
`endif
  output logic                   pipe_stall
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_MAX);

  logic [RFIDX_WIDTH-1:0] r_fifo_idx  [FIFO_DEPTH];
  logic [XLEN-1:0]        r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0]     r_rd_ptr, r_wr_ptr;
  logic [c_CNT_W-1:0]     r_count;
  logic [c_STV_W-1:0]     r_starve;

  logic                   w_empty, w_not_full, w_pipe_req, w_lu_push, w_force;
  logic                   w_wen, w_pop, w_stall, w_bypass, w_push;
  logic [RFIDX_WIDTH-1:0] w_waddr, w_head_idx;
  logic [XLEN-1:0]        w_wdata, w_head_data;

  assign w_empty     = (r_count == '0);
  assign w_not_full  = (r_count < c_DEPTH);
  assign w_pipe_req  = wb_reg_write && (rd_index != '0);
  assign w_lu_push   = lu_valid && lu_ready;
  assign w_force     = (r_starve == c_STV_MAX) && !w_empty;
  assign w_head_idx  = r_fifo_idx[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Priority: forced drain, pipeline, buffered result, direct bypass.
  always_comb begin
    w_wen    = 1'b0;
    w_waddr  = '0;
    w_wdata  = '0;
    w_pop    = 1'b0;
    w_stall  = 1'b0;
    w_bypass = 1'b0;
    if (w_force) begin
      w_wen   = 1'b1;
      w_waddr = w_head_idx;
      w_wdata = w_head_data;
      w_pop   = 1'b1;
      w_stall = 1'b1;
    end else if (w_pipe_req) begin
      w_wen   = 1'b1;
      w_waddr = rd_index;
      w_wdata = wb_memtoreg ? m_data : ex_result;
    end else if (!w_empty) begin
      w_wen   = 1'b1;
      w_waddr = w_head_idx;
      w_wdata = w_head_data;
      w_pop   = 1'b1;
    end else if (w_lu_push && (lu_rd_index != '0)) begin
      w_wen    = 1'b1;
      w_waddr  = lu_rd_index;
      w_wdata  = lu_data;
      w_bypass = 1'b1;
    end
  end

  // x0 results are accepted but never stored.
  assign w_push = w_lu_push && (lu_rd_index != '0) && !w_bypass;

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign lu_ready   = rst_n & w_not_full;
  assign rf_wen     = rst_n & w_wen;
  assign pipe_stall = rst_n & w_stall;
  assign rf_waddr   = rst_n ? w_waddr : '0;
  assign rf_wdata   = rst_n ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr]  <= lu_rd_index;
      r_fifo_data[r_wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A non-empty FIFO that does not pop is being blocked by the pipeline.
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (r_starve != c_STV_MAX)
        r_starve <= r_starve + c_STV_W'(1);
    end
  end

`ifdef WB_ARB_SCOREBOARD_EN
  localparam int c_NREG = 2 ** RFIDX_WIDTH;

  logic [c_NREG-1:0]      r_pending, w_set, w_clr;
  logic [RFIDX_WIDTH-1:0] w_clr_idx;

  assign w_clr_idx = w_bypass ? lu_rd_index : w_head_idx;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_bypass || w_pop)                 w_clr[w_clr_idx]   = 1'b1;
    if (lu_issue && (lu_issue_rd != '0))   w_set[lu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign rs_hazard = r_pending[chk_rs1] | r_pending[chk_rs2];
`endif

endmodule

`default_nettype wire
